// File: rtl/mul_seq.sv
// mul_seq: multi-cycle 32x32 multiplier for MUL / UMULL / SMULL.
// Radix-2 shift-add over a 64-bit accumulator, 32 RUN steps, one FIX step
// for sign correction, one DONE cycle. Latency is fixed at 34 cycles from
// the accepting edge to the return to IDLE, independent of operand values.
module mul_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  ALUControl,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] ResultLo,
    output logic [31:0] ResultHi,
    output logic [1:0]  MulFlags
);

    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_UMULL = 3'b110;
    localparam logic [2:0] OP_SMULL = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  count;
    logic [31:0] mcand;      // multiplicand magnitude
    logic [63:0] acc;        // {partial high, remaining multiplier / low product}
    logic        sign;       // final negate request (SMULL only)
    logic        is_mul;     // 32-bit MUL: high word forced to zero

    logic        op_valid;
    logic        accept;
    logic        is_smull_in;
    logic [31:0] abs_a, abs_b;
    logic [32:0] add_sum;
    logic [63:0] acc_step;
    logic [63:0] acc_fix;
    logic [31:0] res_lo_nxt, res_hi_nxt;
    logic [1:0]  flags_nxt;

    assign op_valid    = (ALUControl == OP_MUL) || (ALUControl == OP_UMULL) ||
                         (ALUControl == OP_SMULL);
    assign is_smull_in = (ALUControl == OP_SMULL);

    // SMULL works on magnitudes; 0x80000000 maps onto itself, which is the
    // correct unsigned magnitude 2^31.
    assign abs_a = (is_smull_in && SrcA[31]) ? (~SrcA + 32'd1) : SrcA;
    assign abs_b = (is_smull_in && SrcB[31]) ? (~SrcB + 32'd1) : SrcB;

    // One shift-add step: add multiplicand into the high half when the
    // current multiplier LSB is set, then shift the whole 65-bit value right.
    assign add_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
    assign acc_step = {add_sum, acc[31:1]};

    // Sign correction applied in FIX.
    assign acc_fix = sign ? (~acc + 64'd1) : acc;

    // Final result word and flag formation, committed on the FIX -> DONE edge.
    always_comb begin
        res_lo_nxt = acc_fix[31:0];
        res_hi_nxt = acc_fix[63:32];
        flags_nxt  = {acc_fix[63], (acc_fix == 64'd0)};
        if (is_mul) begin
            res_hi_nxt = 32'd0;
            flags_nxt  = {acc_fix[31], (acc_fix[31:0] == 32'd0)};
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE: begin
                if (start && op_valid) begin
                    state_nxt = RUN;
                    accept    = 1'b1;
                end
            end
            RUN: begin
                if (flush)
                    state_nxt = IDLE;
                else if (count == 5'd31)
                    state_nxt = FIX;
            end
            FIX: begin
                if (flush)
                    state_nxt = IDLE;
                else
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset wins over flush and start.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Step counter: cleared on accept, advanced once per RUN step.
    always_ff @(posedge clk) begin
        if (reset)
            count <= 5'd0;
        else if (accept)
            count <= 5'd0;
        else if ((state == RUN) && !flush)
            count <= count + 5'd1;
        else if (flush && (state == RUN || state == FIX))
            count <= 5'd0;
    end

    // Operand latch and accumulator; untouched while busy except by stepping.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= 32'd0;
            acc    <= 64'd0;
            sign   <= 1'b0;
            is_mul <= 1'b0;
        end else if (accept) begin
            mcand  <= abs_a;
            acc    <= {32'd0, abs_b};
            sign   <= is_smull_in & (SrcA[31] ^ SrcB[31]);
            is_mul <= (ALUControl == OP_MUL);
        end else if ((state == RUN) && !flush) begin
            acc    <= acc_step;
        end
    end

    // Result registers: updated only when an operation completes, so they
    // hold through flushes and until the next operation finishes.
    always_ff @(posedge clk) begin
        if (reset) begin
            ResultLo <= 32'd0;
            ResultHi <= 32'd0;
            MulFlags <= 2'b00;
        end else if ((state == FIX) && !flush) begin
            ResultLo <= res_lo_nxt;
            ResultHi <= res_hi_nxt;
            MulFlags <= flags_nxt;
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: table-driven vectors through a scoreboard queue, plus
// hand-written sequences for busy-start, flush, reset and invalid-op cases.
module tb_mul_seq;

    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_UMULL = 3'b110;
    localparam logic [2:0] OP_SMULL = 3'b111;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  ALUControl;
    logic [31:0] SrcA, SrcB;
    logic        busy, done;
    logic [31:0] ResultLo, ResultHi;
    logic [1:0]  MulFlags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [1:0]  fl;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    exp_t last;

    mul_seq dut (
        .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
        .SrcA(SrcA), .SrcB(SrcB), .flush(flush), .busy(busy), .done(done),
        .ResultLo(ResultLo), .ResultHi(ResultHi), .MulFlags(MulFlags)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_e(input logic [31:0] lo, input logic [31:0] hi, input logic [1:0] fl);
        exp_t e;
        e.lo = lo; e.hi = hi; e.fl = fl;
        return e;
    endfunction

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi, input logic [31:0] lo, input logic [1:0] fl);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.e = mk_e(lo, hi, fl);
        return v;
    endfunction

    // Reference product using the language multiplier on extended operands.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb, p;
        exp_t e;
        if (op == OP_SMULL) begin
            xa = {{32{a[31]}}, a};
            xb = {{32{b[31]}}, b};
        end else begin
            xa = {32'd0, a};
            xb = {32'd0, b};
        end
        p = xa * xb;
        if (op == OP_MUL) begin
            e.lo = p[31:0];
            e.hi = 32'd0;
            e.fl = {p[31], (p[31:0] == 32'd0)};
        end else begin
            e.lo = p[31:0];
            e.hi = p[63:32];
            e.fl = {p[63], (p == 64'd0)};
        end
        return e;
    endfunction

    // Present a start for one cycle; returns just after the accepting edge.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input exp_t e, input bit track);
        @(negedge clk);
        ALUControl = op; SrcA = a; SrcB = b; start = 1'b1;
        if (track) sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait for done (bounded), check latency, results, pulse width and hold.
    // n0 = number of edges already seen since (and including) the accepting edge.
    task automatic wait_done(input string name, input int n0);
        int   n;
        bit   seen;
        exp_t e;
        n = n0;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        chk({name, " done_seen"}, {63'd0, seen}, 64'd1);
        if (!seen) return;
        chk({name, " latency"}, n, 64'd34);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: done with no expected entry", name);
            return;
        end
        e = sb.pop_front();
        chk({name, " lo"}, ResultLo, e.lo);
        chk({name, " hi"}, ResultHi, e.hi);
        chk({name, " flags"}, MulFlags, e.fl);
        @(posedge clk);
        @(negedge clk);
        chk({name, " pulse_end"}, {done, busy}, 2'b00);
        repeat (2) @(negedge clk);
        chk({name, " hold"}, {ResultHi, ResultLo, 30'd0, MulFlags}, {e.hi, e.lo, 30'd0, e.fl});
        last = e;
    endtask

    vec_t tbl[14];

    initial begin
        bit any_done;

        tbl[0]  = mk(OP_MUL,   32'd7,        32'd6,        32'h0,        32'h0000002A, 2'b00);
        tbl[1]  = mk(OP_UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2'b10);
        tbl[2]  = mk(OP_SMULL, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 2'b10);
        tbl[3]  = mk(OP_SMULL, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 2'b00);
        tbl[4]  = mk(OP_SMULL, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 2'b10);
        tbl[5]  = mk(OP_MUL,   32'h80000000, 32'h00000002, 32'h0,        32'h00000000, 2'b01);
        tbl[6]  = mk(OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h00000001, 2'b00);
        tbl[7]  = mk(OP_SMULL, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 2'b10);
        tbl[8]  = mk(OP_SMULL, 32'h00000000, 32'h80000000, 32'h0,        32'h00000000, 2'b01);
        tbl[9]  = mk(OP_MUL,   32'h0000FFFF, 32'h00010000, 32'h0,        32'hFFFF0000, 2'b10);
        for (int i = 10; i < 14; i++) begin
            tbl[i].op = (i % 3 == 0) ? OP_MUL : ((i % 3 == 1) ? OP_UMULL : OP_SMULL);
            tbl[i].a  = $urandom;
            tbl[i].b  = $urandom;
            tbl[i].e  = model(tbl[i].op, tbl[i].a, tbl[i].b);
        end

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        ALUControl = 3'b000; SrcA = 32'd0; SrcB = 32'd0;
        last = mk_e(32'd0, 32'd0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {busy, done, ResultHi, ResultLo, MulFlags}, 68'd0);
        reset = 1'b0;

        // Table vectors; the first start lands in the first cycle after reset.
        for (int i = 0; i < 14; i++) begin
            start_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e, 1'b1);
            wait_done($sformatf("vec%0d", i), 1);
        end

        // Invalid op code: start ignored, nothing changes.
        start_op(3'b001, 32'd3, 32'd4, last, 1'b0);
        chk("badop busy", {63'd0, busy}, 64'd0);
        any_done = 1'b0;
        repeat (5) begin @(negedge clk); if (done || busy) any_done = 1'b1; end
        chk("badop quiet", {63'd0, any_done}, 64'd0);

        // Start pulsed on the 5th busy cycle with new operands is ignored.
        start_op(OP_UMULL, 32'd0, 32'h12345678, mk_e(32'd0, 32'd0, 2'b01), 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        ALUControl = OP_SMULL; SrcA = 32'h00000009; SrcB = 32'h00000005; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("busy_start", 6);

        // Flush at RUN count 10: back to IDLE, no done, prior results kept.
        start_op(OP_MUL, 32'd7, 32'd6, last, 1'b0);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_run state", {done, busy}, 2'b00);
        chk("flush_run results", {ResultHi, ResultLo, 30'd0, MulFlags}, {last.hi, last.lo, 30'd0, last.fl});
        any_done = 1'b0;
        repeat (40) begin @(negedge clk); if (done) any_done = 1'b1; end
        chk("flush_run no_done", {63'd0, any_done}, 64'd0);

        // Flush in FIX: also aborts with no done.
        start_op(OP_UMULL, 32'h11111111, 32'h22222222, last, 1'b0);
        repeat (32) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        any_done = 1'b0;
        repeat (4) begin @(negedge clk); if (done || busy) any_done = 1'b1; end
        chk("flush_fix quiet", {63'd0, any_done}, 64'd0);
        chk("flush_fix results", {ResultHi, ResultLo, 30'd0, MulFlags}, {last.hi, last.lo, 30'd0, last.fl});

        // Flush held high in IDLE does not block an accepted start.
        flush = 1'b1;
        start_op(OP_SMULL, 32'hFFFFFFF9, 32'h00000006, model(OP_SMULL, 32'hFFFFFFF9, 32'h00000006), 1'b1);
        flush = 1'b0;
        wait_done("flush_idle", 1);

        // Reset at RUN count 20 clears everything; restart one cycle later.
        start_op(OP_UMULL, 32'hDEADBEEF, 32'h00000010, last, 1'b0);
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_mid", {busy, done, ResultHi, ResultLo, MulFlags}, 68'd0);
        start_op(OP_UMULL, 32'h00010000, 32'h00010000, mk_e(32'd0, 32'd1, 2'b00), 1'b1);
        wait_done("after_reset", 1);

        // Reset wins over a coincident valid start.
        @(negedge clk);
        ALUControl = OP_MUL; SrcA = 32'd2; SrcB = 32'd3; start = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; reset = 1'b0;
        chk("reset_vs_start", {busy, done, ResultHi, ResultLo, MulFlags}, 68'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
